// File: rtl/unified_ram_dp.sv
// Dual-port unified memory: a read/write/swap data port and a read-only fetch port.
// After reset it can zero every word, one per cycle, before accepting commands.
module unified_ram_dp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 4,
    parameter int PC_W           = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   ramaddr,
    input  logic [1:0]          RW,
    input  logic [DATA_W-1:0]   i_databus,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [PC_W-1:0]     ProgC,
    output logic [DATA_W-1:0]   o_databus,
    output logic                o_data_valid,
    output logic [DATA_W-1:0]   o_instrfetch,
    output logic                o_instr_valid,
    output logic                o_fetch_err,
    output logic                o_ready
);

    localparam int             DEPTH    = 1 << ADDR_W;
    localparam int             NB       = DATA_W / 8;
    localparam logic [PC_W:0]  DEPTH_PC = (PC_W + 1)'(DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   wr_word;
    logic                fetch_oob;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [DATA_W-1:0]   fetch_word;

    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] merged;
        merged = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[8*i +: 8] = new_w[8*i +: 8];
        end
        return merged;
    endfunction

    // RW[1] marks write/swap, RW[0] marks read/swap (both produce a result).
    assign run        = (state == ST_RUN);
    assign wr_en      = run && RW[1];
    assign rd_en      = run && RW[0];
    assign rd_word    = mem[ramaddr];
    assign wr_word    = byte_merge(rd_word, i_databus, byte_en);
    assign fetch_oob  = ({1'b0, ProgC} >= DEPTH_PC);
    assign fetch_addr = ProgC[ADDR_W-1:0];
    // Write-first: a fetch hitting the word being written sees the merged value.
    assign fetch_word = (wr_en && (fetch_addr == ramaddr)) ? wr_word : mem[fetch_addr];
    assign o_ready    = run;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        if (state == ST_CLEAR) begin
            clr_cnt_nxt = clr_cnt + 1'b1;
            if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // NOTE: the array has no reset; contents survive reset_n and are zeroed only by the clear sequence.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[ramaddr] <= wr_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            o_databus     <= '0;
            o_data_valid  <= 1'b0;
            o_instrfetch  <= '0;
            o_instr_valid <= 1'b0;
            o_fetch_err   <= 1'b0;
        end else begin
            o_data_valid  <= rd_en;
            o_instr_valid <= run;
            if (rd_en) o_databus <= rd_word;
            if (run) begin
                o_instrfetch <= fetch_oob ? '0 : fetch_word;
                o_fetch_err  <= fetch_oob;
            end
        end
    end

endmodule

// File: tb/tb_unified_ram_dp.sv
// Directed bench for unified_ram_dp: one instance clears on reset, a second
// keeps contents and is preloaded through its data port for the fetch sweep.
module tb_unified_ram_dp;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;
    localparam logic [1:0] SW   = 2'b11;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        a_rst_n, b_rst_n;
    logic [3:0]  a_addr, b_addr;
    logic [1:0]  a_rw, b_rw;
    logic [31:0] a_wdata, b_wdata;
    logic [3:0]  a_be, b_be;
    logic [7:0]  a_pc, b_pc;
    logic [31:0] a_rdata, b_rdata;
    logic        a_dvalid, b_dvalid;
    logic [31:0] a_ifetch, b_ifetch;
    logic        a_ivalid, b_ivalid;
    logic        a_ferr, b_ferr;
    logic        a_ready, b_ready;

    int checks   = 0;
    int failures = 0;

    unified_ram_dp #(.DATA_W(32), .ADDR_W(4), .PC_W(8), .CLEAR_ON_RESET(1'b1)) dut_a (
        .clock(clock), .reset_n(a_rst_n), .ramaddr(a_addr), .RW(a_rw),
        .i_databus(a_wdata), .byte_en(a_be), .ProgC(a_pc),
        .o_databus(a_rdata), .o_data_valid(a_dvalid), .o_instrfetch(a_ifetch),
        .o_instr_valid(a_ivalid), .o_fetch_err(a_ferr), .o_ready(a_ready)
    );

    unified_ram_dp #(.DATA_W(32), .ADDR_W(4), .PC_W(8), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clock(clock), .reset_n(b_rst_n), .ramaddr(b_addr), .RW(b_rw),
        .i_databus(b_wdata), .byte_en(b_be), .ProgC(b_pc),
        .o_databus(b_rdata), .o_data_valid(b_dvalid), .o_instrfetch(b_ifetch),
        .o_instr_valid(b_ivalid), .o_fetch_err(b_ferr), .o_ready(b_ready)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic a_cmd(input logic [1:0] rw, input logic [3:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
        a_rw = rw; a_addr = addr; a_wdata = data; a_be = be;
    endtask

    // Number of edges until o_ready rises, capped at 40.
    task automatic count_to_ready(output int cycles);
        cycles = 0;
        while (!a_ready && cycles < 40) begin
            tick();
            cycles++;
            checks++;
            if (!a_ready && a_dvalid !== 1'b0) begin
                failures++;
                $display("FAIL clear_dvalid cycle=%0d got=%b want=0", cycles, a_dvalid);
            end
        end
    endtask

    function automatic logic [31:0] pre_word(input int i);
        return {i[7:0], 8'hA5, 8'(15 - i), 8'h3C};
    endfunction

    task automatic test_reset();
        int n;
        a_rst_n = 1'b0;
        a_cmd(IDLE, 4'd0, 32'h0, 4'h0);
        a_pc = 8'd0;
        tick();
        checks++;
        if ({a_ready, a_dvalid, a_ivalid, a_ferr} !== 4'b0000 || a_rdata !== 32'h0 || a_ifetch !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h/%h want=0000/0/0",
                     {a_ready, a_dvalid, a_ivalid, a_ferr}, a_rdata, a_ifetch);
        end
        a_rst_n = 1'b1;
        count_to_ready(n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL clear_length got=%0d want=16", n);
        end
        checks++;
        if (a_ivalid !== 1'b0) begin
            failures++;
            $display("FAIL first_run_ivalid got=%b want=0", a_ivalid);
        end
        tick();
        checks++;
        if (a_ivalid !== 1'b1) begin
            failures++;
            $display("FAIL run_ivalid got=%b want=1", a_ivalid);
        end
    endtask

    task automatic test_byte_write();
        a_cmd(WR, 4'd3, 32'hAAAA_AAAA, 4'b1111);
        tick();
        checks++;
        if (a_dvalid !== 1'b0) begin
            failures++;
            $display("FAIL write_no_valid got=%b want=0", a_dvalid);
        end
        a_cmd(WR, 4'd3, 32'h0000_00BB, 4'b0001);
        tick();
        a_cmd(WR, 4'd3, 32'hFFFF_FFFF, 4'b0000);
        tick();
        a_cmd(RD, 4'd3, 32'h0, 4'h0);
        tick();
        checks++;
        if (a_rdata !== 32'hAAAA_AABB || a_dvalid !== 1'b1) begin
            failures++;
            $display("FAIL byte_write got=%h/%b want=aaaaaabb/1", a_rdata, a_dvalid);
        end
    endtask

    task automatic test_swap();
        a_cmd(WR, 4'd5, 32'h1234_5678, 4'b1111);
        tick();
        a_cmd(SW, 4'd5, 32'hCAFE_F00D, 4'b1111);
        tick();
        checks++;
        if (a_rdata !== 32'h1234_5678 || a_dvalid !== 1'b1) begin
            failures++;
            $display("FAIL swap_old got=%h/%b want=12345678/1", a_rdata, a_dvalid);
        end
        a_cmd(RD, 4'd5, 32'h0, 4'h0);
        tick();
        checks++;
        if (a_rdata !== 32'hCAFE_F00D || a_dvalid !== 1'b1) begin
            failures++;
            $display("FAIL swap_new got=%h/%b want=cafef00d/1", a_rdata, a_dvalid);
        end
        a_cmd(IDLE, 4'd0, 32'h0, 4'h0);
        tick();
        checks++;
        if (a_rdata !== 32'hCAFE_F00D || a_dvalid !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got=%h/%b want=cafef00d/0", a_rdata, a_dvalid);
        end
    endtask

    task automatic test_collision();
        a_cmd(WR, 4'd7, 32'hDEAD_BEEF, 4'b1111);
        a_pc = 8'd7;
        tick();
        checks++;
        if (a_ifetch !== 32'hDEAD_BEEF || a_ivalid !== 1'b1 || a_ferr !== 1'b0) begin
            failures++;
            $display("FAIL collision got=%h/%b/%b want=deadbeef/1/0", a_ifetch, a_ivalid, a_ferr);
        end
        a_cmd(IDLE, 4'd0, 32'h0, 4'h0);
        a_pc = 8'd3;
        tick();
        checks++;
        if (a_ifetch !== 32'hAAAA_AABB) begin
            failures++;
            $display("FAIL fetch_addr3 got=%h want=aaaaaabb", a_ifetch);
        end
        a_pc = 8'd0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        a_rst_n = 1'b0;
        #1;
        checks++;
        if (a_rdata !== 32'h0 || a_ifetch !== 32'h0 || a_ready !== 1'b0 || a_ivalid !== 1'b0) begin
            failures++;
            $display("FAIL run_reset_async got=%h/%h/%b/%b want=0/0/0/0", a_rdata, a_ifetch, a_ready, a_ivalid);
        end
        tick();
        a_rst_n = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        a_rst_n = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_dvalid, a_ivalid, a_ferr} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_reset_async got=%b want=0000", {a_ready, a_dvalid, a_ivalid, a_ferr});
        end
        tick();
        tick();
        a_rst_n = 1'b1;
        count_to_ready(n);
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL restart_clear_length got=%0d want=16", n);
        end
    endtask

    task automatic test_back_to_back_reads();
        for (int i = 0; i < 16; i++) begin
            a_cmd(RD, 4'(i), 32'h0, 4'h0);
            tick();
            checks++;
            if (a_rdata !== 32'h0 || a_dvalid !== 1'b1) begin
                failures++;
                $display("FAIL cleared_read addr=%0d got=%h/%b want=0/1", i, a_rdata, a_dvalid);
            end
        end
        a_cmd(IDLE, 4'd0, 32'h0, 4'h0);
        tick();
        checks++;
        if (a_dvalid !== 1'b0) begin
            failures++;
            $display("FAIL valid_drop got=%b want=0", a_dvalid);
        end
    endtask

    task automatic test_fetch_sweep();
        b_rst_n = 1'b0;
        b_rw = IDLE; b_addr = 4'd0; b_wdata = 32'h0; b_be = 4'h0; b_pc = 8'd0;
        tick();
        checks++;
        if (b_ready !== 1'b1 || b_ifetch !== 32'h0 || b_ferr !== 1'b0) begin
            failures++;
            $display("FAIL noclear_reset got=%b/%h/%b want=1/0/0", b_ready, b_ifetch, b_ferr);
        end
        b_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b_rw = WR; b_addr = 4'(i); b_wdata = pre_word(i); b_be = 4'hF;
            tick();
        end
        b_rw = IDLE; b_be = 4'h0;
        for (int i = 0; i < 16; i++) begin
            b_pc = 8'(i);
            tick();
            checks++;
            if (b_ifetch !== pre_word(i) || b_ivalid !== 1'b1 || b_ferr !== 1'b0) begin
                failures++;
                $display("FAIL fetch pc=%0d got=%h/%b/%b want=%h/1/0", i, b_ifetch, b_ivalid, b_ferr, pre_word(i));
            end
        end
        b_pc = 8'd16;
        tick();
        checks++;
        if (b_ifetch !== 32'h0 || b_ferr !== 1'b1 || b_ivalid !== 1'b1) begin
            failures++;
            $display("FAIL fetch_oob16 got=%h/%b/%b want=0/1/1", b_ifetch, b_ferr, b_ivalid);
        end
        b_pc = 8'd255;
        tick();
        checks++;
        if (b_ifetch !== 32'h0 || b_ferr !== 1'b1) begin
            failures++;
            $display("FAIL fetch_oob255 got=%h/%b want=0/1", b_ifetch, b_ferr);
        end
        b_pc = 8'd2;
        tick();
        checks++;
        if (b_ifetch !== pre_word(2) || b_ferr !== 1'b0) begin
            failures++;
            $display("FAIL fetch_recover got=%h/%b want=%h/0", b_ifetch, b_ferr, pre_word(2));
        end
    endtask

    initial begin
        a_rst_n = 1'b0;
        b_rst_n = 1'b0;
        a_cmd(IDLE, 4'd0, 32'h0, 4'h0);
        a_pc = 8'd0;
        b_rw = IDLE; b_addr = 4'd0; b_wdata = 32'h0; b_be = 4'h0; b_pc = 8'd0;
        @(negedge clock);
        test_reset();
        test_byte_write();
        test_swap();
        test_collision();
        test_reset_mid_clear();
        test_back_to_back_reads();
        test_fetch_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_ram_dp.md
# unified_ram_dp

Parametrised dual-port unified memory for the 32-bit CPU: one read/write data port driven by the load/store path (`ramaddr`, `RW`) and one read-only instruction-fetch port driven by the program counter (`ProgC`). It is the successor to the fixed 16-word RAM and adds:
- configurable width and depth
- byte-enable writes and an atomic swap mode
- registered outputs with valid flags
- a hardware clear sequence after reset, with a ready flag

It sits between the control unit and the register file/ALU data bus.

## Interface
- `DATA_W`, 32, data word width; must be a multiple of 8.
- `ADDR_W`, 4, address width; depth `DEPTH` = 2^`ADDR_W` words.
- `PC_W`, 8, program counter width; must be >= `ADDR_W`.
- `CLEAR_ON_RESET`, 1, 1 = zero all words after reset; 0 = skip clear (contents preserved, e.g. preloaded by `$readmemb`).
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ramaddr`  in  `ADDR_W`  data-port word address.
- `RW`  in  2  data-port command: 00 idle, 01 read, 10 write, 11 swap.
- `i_databus`  in  `DATA_W`  write data.
- `byte_en`  in  `DATA_W`/8  per-byte write enable for write and swap; bit i covers bits [8i+7:8i].
- `ProgC`  in  `PC_W`  fetch word address.
- `o_databus`  out  `DATA_W`  registered read/swap result.
- `o_data_valid`  out  1  high for one cycle when `o_databus` holds a new result.
- `o_instrfetch`  out  `DATA_W`  registered fetched instruction.
- `o_instr_valid`  out  1  high when `o_instrfetch` holds a fetch issued in the previous cycle.
- `o_fetch_err`  out  1  registered; high when the fetch address was >= `DEPTH`.
- `o_ready`  out  1  high when commands are accepted (state RUN).

## Operation
- States: CLEAR and RUN. Reset enters CLEAR if `CLEAR_ON_RESET`=1, otherwise RUN.
- CLEAR:
  - An `ADDR_W`-bit counter starts at 0 and writes 0 to one word per cycle.
  - After word `DEPTH`-1 is written, the next cycle is RUN.
  - CLEAR lasts exactly `DEPTH` cycles.
  - `RW`, `ProgC` and `byte_en` are ignored; `o_ready`, `o_data_valid` and `o_instr_valid` are 0.
- RUN, data port:
  - 01 read: `o_databus` <= mem[`ramaddr`].
  - 10 write: mem[`ramaddr`] bytes with `byte_en`=1 take `i_databus`; `o_databus` holds its value; no valid pulse.
  - 11 swap: in one cycle, `o_databus` <= old mem[`ramaddr`] (pre-write), then the byte-enabled write takes effect.
  - 00 idle: no memory change; outputs hold.
- RUN, fetch port:
  - A fetch is issued every RUN cycle.
  - If `ProgC` < `DEPTH`: `o_instrfetch` <= mem[`ProgC`], `o_fetch_err` <= 0.
  - Otherwise: `o_instrfetch` <= 0, `o_fetch_err` <= 1.
- Collision (fetch address equals a write/swap address in the same cycle): write-first. The fetch returns the post-write merged word.
- Data read and fetch may target the same address in the same cycle with no conflict.
- Write with `byte_en`=0: no memory change.

## Timing
- Reset values (asynchronous):
  - `o_databus`=0, `o_instrfetch`=0.
  - `o_data_valid`=0, `o_instr_valid`=0, `o_fetch_err`=0.
  - Clear counter = 0.
  - `o_ready`=0 if `CLEAR_ON_RESET`=1, else 1.
- Memory contents are not reset by `reset_n`. They are only zeroed by the CLEAR sequence.
- Read/swap latency: 1 cycle. A command sampled at edge N gives result and `o_data_valid`=1 after edge N. Valid drops after edge N+1 unless a new read or swap was issued.
- Fetch latency: 1 cycle. `o_instr_valid` is 1 every RUN cycle following a RUN cycle.
- Back-to-back reads and swaps: one per cycle, with no bubbles.
- A write at edge N is visible to a data read sampled at edge N+1.
- `o_ready` rises on the edge that completes the last clear write. The first command is accepted at the following edge.
- Reset asserted mid-CLEAR or mid-RUN:
  - Outputs clear immediately.
  - A write in flight at the reset edge is not guaranteed.
  - After release, the clear sequence restarts from word 0.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, `DEPTH`=16 -> `o_ready`=0 for exactly 16 cycles, then 1; subsequent reads of addresses 0..15 all return 0 with `o_data_valid`=1 one cycle after each read.
- Write 32'hAAAA_AAAA to address 3 with `byte_en`=4'b1111, then write 32'h0000_00BB with `byte_en`=4'b0001, then read address 3 -> `o_databus`=32'hAAAA_AABB.
- Swap address 5 (holding 32'h1234_5678) with 32'hCAFE_F00D, `byte_en`=1111, then read address 5 -> swap returns 32'h1234_5678, read returns 32'hCAFE_F00D.
- Same-cycle write of 32'hDEAD_BEEF to address 7 with `ProgC`=7 -> next cycle `o_instrfetch`=32'hDEAD_BEEF (write-first).
- Sweep `ProgC` 0..15 after preloading with `CLEAR_ON_RESET`=0, then set `ProgC`=16 -> each fetch returns the preloaded word one cycle later with `o_instr_valid`=1; at `ProgC`=16, `o_instrfetch`=0 and `o_fetch_err`=1.
- Assert `reset_n`=0 at clear count 9, release after 2 cycles -> outputs 0 immediately; `o_ready` rises exactly 16 cycles after release.
